// File: rtl/proc_pkg.sv
// Shared processor constants: instruction types, function codes, stage classes and
// sequencer states. The control unit decodes against the same encodings.
package proc_pkg;

  // InstructionType encodings
  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_S = 2'b01;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_J = 2'b11;

  // FunctionCode values for the non-register instructions
  localparam logic [4:0] FC_ANDI = 5'h0c;
  localparam logic [4:0] FC_ADDI = 5'h08;
  localparam logic [4:0] FC_LW   = 5'h13;
  localparam logic [4:0] FC_SW   = 5'h15;
  localparam logic [4:0] FC_BEQ  = 5'h04;
  localparam logic [4:0] FC_J    = 5'h02;
  localparam logic [4:0] FC_JAL  = 5'h03;

  // Stage path taken by an instruction after decode
  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_LINK   = 3'd6
  } stage_class_e;

  // One-hot sequencer states
  typedef enum logic [7:0] {
    StIdle    = 8'b0000_0001,
    StIf      = 8'b0000_0010,
    StId      = 8'b0000_0100,
    StEx      = 8'b0000_1000,
    StMem     = 8'b0001_0000,
    StMemWait = 8'b0010_0000,
    StWb      = 8'b0100_0000,
    StFault   = 8'b1000_0000
  } seq_state_e;

  // Classes that visit the data-memory stage after EX
  function automatic logic class_uses_mem(stage_class_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/stage_path_decode.sv
// Combinational decode of {InstructionType, FunctionCode} into the stage-path class.
// Register and S-type instructions are all ALU operations; I- and J-type rely on the
// function code, and anything unlisted is flagged illegal and treated as a NOP.
module stage_path_decode
  import proc_pkg::*;
(
  input  logic [1:0]   instr_type_i,
  input  logic [4:0]   func_code_i,
  output stage_class_e class_o,
  output logic         illegal_o
);

  // Map type/code to a path class, defaulting to an illegal NOP
  always_comb begin
    class_o   = CLS_NOP;
    illegal_o = 1'b0;
    case (instr_type_i)
      TYPE_R, TYPE_S: class_o = CLS_ALU;
      TYPE_I: begin
        case (func_code_i)
          FC_ANDI, FC_ADDI: class_o = CLS_ALU;
          FC_LW:            class_o = CLS_LOAD;
          FC_SW:            class_o = CLS_STORE;
          FC_BEQ:           class_o = CLS_BRANCH;
          default:          illegal_o = 1'b1;
        endcase
      end
      TYPE_J: begin
        case (func_code_i)
          FC_J:    class_o = CLS_JUMP;
          FC_JAL:  class_o = CLS_LINK;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer. Emits one-hot stage strobes (IF/ID/EX/MEM/WB) whose path
// per instruction is chosen in ID, waits on the data-memory ready handshake with a
// timeout, and counts retired instructions.
module stage_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [1:0]       InstructionType,
  input  logic [4:0]       FunctionCode,
  input  logic             mem_ready,
  output logic             en_instruction_fetch,
  output logic             en_instruction_decode,
  output logic             en_execute,
  output logic             en_memory_access,
  output logic             en_write_back,
  output logic             instr_done,
  output logic             illegal_instr,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned       TimerW    = $clog2(MEM_TIMEOUT + 1);
  // Timer value seen in the last permitted MEM_WAIT cycle
  localparam logic [TimerW-1:0] TimerLast = TimerW'(MEM_TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  stage_class_e      class_q, class_d;
  stage_class_e      dec_class;
  logic              dec_illegal;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              done;
  logic              illegal;

  stage_path_decode u_decode (
    .instr_type_i (InstructionType),
    .func_code_i  (FunctionCode),
    .class_o      (dec_class),
    .illegal_o    (dec_illegal)
  );

  // Next-state selection; done marks the last stage cycle of the current instruction
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    timer_d = timer_q;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StIf;
      end
      StIf: state_d = StId;
      StId: begin
        class_d = dec_class;
        illegal = dec_illegal;
        case (dec_class)
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_d = StEx;
          CLS_LINK:                                 state_d = StWb;
          default:                                  done    = 1'b1;
        endcase
      end
      StEx: begin
        if (class_q == CLS_ALU)             state_d = StWb;
        else if (class_uses_mem(class_q))   state_d = StMem;
        else                                done    = 1'b1;
      end
      StMem: begin
        if (mem_ready) begin
          if (class_q == CLS_LOAD) state_d = StWb;
          else                     done    = 1'b1;
        end else begin
          state_d = StMemWait;
          timer_d = '0;
        end
      end
      StMemWait: begin
        timer_d = timer_q + TimerW'(1);
        // A ready arriving in the final allowed cycle still completes the access
        if (mem_ready) begin
          if (class_q == CLS_LOAD) state_d = StWb;
          else                     done    = 1'b1;
        end else if (timer_q == TimerLast) begin
          state_d = StFault;
        end
      end
      StWb:    done = 1'b1;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    if (done) state_d = run ? StIf : StIdle;
  end

  // State register with strobes and fault registered from the upcoming state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= StIdle;
      en_instruction_fetch  <= 1'b0;
      en_instruction_decode <= 1'b0;
      en_execute            <= 1'b0;
      en_memory_access      <= 1'b0;
      en_write_back         <= 1'b0;
      fault                 <= 1'b0;
    end else begin
      state_q               <= state_d;
      en_instruction_fetch  <= (state_d == StIf);
      en_instruction_decode <= (state_d == StId);
      en_execute            <= (state_d == StEx);
      en_memory_access      <= (state_d == StMem);
      en_write_back         <= (state_d == StWb);
      fault                 <= (state_d == StFault);
    end
  end

  // Latched class, memory-wait timer and retired-instruction counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      class_q     <= CLS_NOP;
      timer_q     <= '0;
      instr_count <= '0;
    end else begin
      class_q <= class_d;
      timer_q <= timer_d;
      if (done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign instr_done    = done;
  assign illegal_instr = illegal;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus randomized instruction
// streams checked against a per-instruction stage-path model.
module tb_stage_sequencer;
  import proc_pkg::*;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  localparam int C_NOP = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3;
  localparam int C_BRANCH = 4, C_JUMP = 5, C_LINK = 6;

  // Strobe vector layout {IF, ID, EX, MEM, WB}
  localparam logic [4:0] S_IF = 5'b10000, S_ID = 5'b01000, S_EX = 5'b00100;
  localparam logic [4:0] S_MEM = 5'b00010, S_WB = 5'b00001, S_NONE = 5'b00000;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            run;
  logic [1:0]      itype;
  logic [4:0]      fcode;
  logic            mem_ready;
  logic            en_if, en_id, en_ex, en_mem, en_wb;
  logic            instr_done, illegal_instr, fault;
  logic [CntW-1:0] instr_count;
  logic [4:0]      strobes;

  int n_checks = 0;
  int n_pass = 0;
  int model_count = 0;

  logic [4:0] known_codes [7] = '{FC_ANDI, FC_ADDI, FC_LW, FC_SW, FC_BEQ, FC_J, FC_JAL};

  assign strobes = {en_if, en_id, en_ex, en_mem, en_wb};

  always #5 clock = ~clock;

  stage_sequencer #(
    .MEM_TIMEOUT (MemTimeout),
    .CNT_W       (CntW)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .run                   (run),
    .InstructionType       (itype),
    .FunctionCode          (fcode),
    .mem_ready             (mem_ready),
    .en_instruction_fetch  (en_if),
    .en_instruction_decode (en_id),
    .en_execute            (en_ex),
    .en_memory_access      (en_mem),
    .en_write_back         (en_wb),
    .instr_done            (instr_done),
    .illegal_instr         (illegal_instr),
    .fault                 (fault),
    .instr_count           (instr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Path class straight from the instruction-set table
  function automatic int classify(logic [1:0] t, logic [4:0] c);
    if (t == TYPE_R || t == TYPE_S) return C_ALU;
    if (t == TYPE_I) begin
      if (c == FC_ANDI || c == FC_ADDI) return C_ALU;
      if (c == FC_LW) return C_LOAD;
      if (c == FC_SW) return C_STORE;
      if (c == FC_BEQ) return C_BRANCH;
    end
    if (t == TYPE_J) begin
      if (c == FC_J) return C_JUMP;
      if (c == FC_JAL) return C_LINK;
    end
    return C_NOP;
  endfunction

  // Runs one instruction starting in its IF cycle; waits = cycles spent in MEM_WAIT
  task automatic run_instr(input logic [1:0] t, input logic [4:0] c, input int waits,
                           input bit run_after, input string name);
    logic [4:0] exp_q[$];
    int cls;
    int mem_idx;
    int last;
    cls = classify(t, c);
    mem_idx = -1;
    exp_q.push_back(S_IF);
    exp_q.push_back(S_ID);
    case (cls)
      C_ALU: begin exp_q.push_back(S_EX); exp_q.push_back(S_WB); end
      C_LOAD, C_STORE: begin
        exp_q.push_back(S_EX);
        mem_idx = exp_q.size();
        exp_q.push_back(S_MEM);
        repeat (waits) exp_q.push_back(S_NONE);
        if (cls == C_LOAD) exp_q.push_back(S_WB);
      end
      C_BRANCH: exp_q.push_back(S_EX);
      C_LINK:   exp_q.push_back(S_WB);
      default: ;
    endcase
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      // Type/code only matter in ID; other inputs only matter where the path samples them
      itype = (i == 1) ? t : 2'($urandom);
      fcode = (i == 1) ? c : 5'($urandom);
      if (mem_idx < 0 || i < mem_idx) mem_ready = 1'($urandom);
      else mem_ready = (i >= mem_idx + waits);
      run = (i == last) ? run_after : 1'($urandom);
      #1;
      n_checks++;
      if (strobes !== exp_q[i])
        $display("FAIL %s cyc%0d strobes: got %b want %b", name, i, strobes, exp_q[i]);
      else n_pass++;
      n_checks++;
      if (instr_done !== (i == last))
        $display("FAIL %s cyc%0d instr_done: got %b want %b", name, i, instr_done, (i == last));
      else n_pass++;
      n_checks++;
      if (illegal_instr !== (i == 1 && cls == C_NOP))
        $display("FAIL %s cyc%0d illegal_instr: got %b want %b", name, i, illegal_instr,
                 (i == 1 && cls == C_NOP));
      else n_pass++;
      n_checks++;
      if (fault !== 1'b0) $display("FAIL %s cyc%0d fault: got %b want 0", name, i, fault);
      else n_pass++;
      @(posedge clock);
      #1;
    end
    model_count++;
    n_checks++;
    if (instr_count !== CntW'(model_count))
      $display("FAIL %s instr_count: got %0d want %0d", name, instr_count, CntW'(model_count));
    else n_pass++;
    n_checks++;
    if (strobes !== (run_after ? S_IF : S_NONE))
      $display("FAIL %s follow-on strobes: got %b want %b", name, strobes,
               (run_after ? S_IF : S_NONE));
    else n_pass++;
  endtask

  // From IDLE, raise run and expect IF on the next edge
  task automatic restart(input string name);
    run = 1'b1;
    tick();
    n_checks++;
    if (strobes !== S_IF) $display("FAIL %s restart: got %b want %b", name, strobes, S_IF);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    itype = TYPE_R;
    fcode = 5'h00;
    model_count = 0;
    #12;
    n_checks++;
    if ({strobes, instr_done, illegal_instr, fault} !== 8'h00)
      $display("FAIL reset outputs: got %b want 00000000", {strobes, instr_done, illegal_instr, fault});
    else n_pass++;
    n_checks++;
    if (instr_count !== '0) $display("FAIL reset instr_count: got %0d want 0", instr_count);
    else n_pass++;
    repeat (2) tick();
    reset_n = 1'b1;
    restart("reset_release");
  endtask

  task automatic test_alu();
    run_instr(TYPE_R, 5'h00, 0, 1'b1, "r_add");
    run_instr(TYPE_I, FC_ADDI, 0, 1'b1, "addi");
  endtask

  task automatic test_load_wait();
    run_instr(TYPE_I, FC_LW, 3, 1'b1, "lw_wait3");
    run_instr(TYPE_I, FC_LW, 0, 1'b1, "lw_nowait");
    run_instr(TYPE_I, FC_LW, MemTimeout, 1'b1, "lw_wait_limit");
    run_instr(TYPE_I, FC_SW, 2, 1'b1, "sw_wait2");
  endtask

  task automatic test_branch_jump_illegal();
    run_instr(TYPE_I, FC_BEQ, 0, 1'b1, "beq");
    run_instr(TYPE_J, FC_J, 0, 1'b1, "j");
    run_instr(TYPE_J, FC_JAL, 0, 1'b1, "jal");
    run_instr(TYPE_I, 5'h1f, 0, 1'b1, "illegal_i");
    run_instr(TYPE_J, 5'h00, 0, 1'b1, "illegal_j");
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [4:0] c;
    bit ra;
    for (int n = 0; n < 40; n++) begin
      t = 2'($urandom);
      c = ($urandom_range(0, 1) == 1) ? known_codes[$urandom_range(0, 6)] : 5'($urandom);
      ra = ($urandom_range(0, 3) != 0);
      run_instr(t, c, $urandom_range(0, MemTimeout), ra, "random");
      if (!ra) restart("random");
    end
  endtask

  task automatic test_run_drop();
    run_instr(TYPE_S, 5'h07, 0, 1'b0, "run_drop");
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (strobes !== S_NONE || instr_done !== 1'b0)
        $display("FAIL run_drop idle: got %b/%b want 00000/0", strobes, instr_done);
      else n_pass++;
    end
    restart("run_drop");
  endtask

  task automatic test_reset_mid_ex();
    itype = TYPE_R;
    fcode = 5'h00;
    run = 1'b1;
    tick();
    tick();
    n_checks++;
    if (strobes !== S_EX) $display("FAIL mid_ex setup: got %b want %b", strobes, S_EX);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({strobes, instr_done, fault} !== 7'h00)
      $display("FAIL mid_ex reset outputs: got %b want 0000000", {strobes, instr_done, fault});
    else n_pass++;
    n_checks++;
    if (instr_count !== '0) $display("FAIL mid_ex instr_count: got %0d want 0", instr_count);
    else n_pass++;
    model_count = 0;
    tick();
    reset_n = 1'b1;
    restart("mid_ex_release");
  endtask

  task automatic test_counter_wrap();
    for (int n = 0; n < 17; n++) run_instr(TYPE_R, 5'($urandom), 0, 1'b1, "wrap");
    n_checks++;
    if (instr_count !== 4'd1) $display("FAIL wrap count: got %0d want 1", instr_count);
    else n_pass++;
  endtask

  task automatic test_fault();
    logic [4:0] exp_f [8] = '{S_IF, S_ID, S_EX, S_MEM, S_NONE, S_NONE, S_NONE, S_NONE};
    itype = TYPE_I;
    fcode = FC_SW;
    mem_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (strobes !== exp_f[i] || fault !== 1'b0 || instr_done !== 1'b0)
        $display("FAIL fault approach cyc%0d: got %b/%b/%b want %b/0/0", i, strobes, fault,
                 instr_done, exp_f[i]);
      else n_pass++;
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i > 1);
      #1;
      n_checks++;
      if (fault !== 1'b1 || strobes !== S_NONE || instr_done !== 1'b0)
        $display("FAIL fault hold cyc%0d: got %b/%b/%b want 1/00000/0", i, fault, strobes,
                 instr_done);
      else n_pass++;
      n_checks++;
      if (instr_count !== CntW'(model_count))
        $display("FAIL fault count: got %0d want %0d", instr_count, CntW'(model_count));
      else n_pass++;
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    run = 1'b0;
    #1;
    n_checks++;
    if (fault !== 1'b0) $display("FAIL fault clear: got %b want 0", fault);
    else n_pass++;
    model_count = 0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (strobes !== S_NONE) $display("FAIL post-fault idle: got %b want 00000", strobes);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch_jump_illegal();
    test_random();
    test_run_drop();
    test_reset_mid_ex();
    test_counter_wrap();
    test_fault();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
